// File: rtl/objects_mux_layered_pkg.sv
// Shared types and helpers for the layered object mux: RGB332/RGB888 types,
// the default transparent colour key and the RGB332 -> 24-bit expansion.
package objects_mux_pkg;

  localparam int NUM_LAYERS_MAX = 16;

  typedef logic [7:0] rgb332_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam rgb332_t TRANSP_KEY_DEF = 8'hFF;

  // Bit-replicating expansion so full-scale 3/2-bit codes map to 8'hFF.
  function automatic rgb888_t expand332(input rgb332_t c);
    rgb888_t o;
    o.r = {c[7:5], c[7:5], c[7:6]};
    o.g = {c[4:2], c[4:2], c[4:3]};
    o.b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return o;
  endfunction

  // True when two or more bits of v are set.
  function automatic logic multi_hot(input logic [NUM_LAYERS_MAX-1:0] v);
    return (v & (v - NUM_LAYERS_MAX'(1))) != '0;
  endfunction

endpackage

// File: rtl/objects_mux_layered_if.sv
// Pixel-side bus of the layered object mux. The master modport is the
// sprite/control side driving layer pixels and rank programming; the slave
// modport is the compositor itself.
interface objects_mux_layered_if #(
  parameter int NUM_LAYERS = 8,
  parameter int RANK_W     = $clog2(NUM_LAYERS)
);

  logic                    startOfFrame;
  logic [NUM_LAYERS-1:0]   layerReq;
  logic [NUM_LAYERS*8-1:0] layerRGB;
  logic [7:0]              backGroundRGB;
  logic                    prioWr;
  logic [RANK_W-1:0]       prioRank;
  logic [RANK_W-1:0]       prioLayer;
  logic [NUM_LAYERS-1:0]   layerEnNext;
  logic [7:0]              redOut;
  logic [7:0]              greenOut;
  logic [7:0]              blueOut;
  logic [NUM_LAYERS-1:0]   collFrame;
  logic                    collAny;

  modport master (
    output startOfFrame, layerReq, layerRGB, backGroundRGB,
           prioWr, prioRank, prioLayer, layerEnNext,
    input  redOut, greenOut, blueOut, collFrame, collAny
  );

  modport slave (
    input  startOfFrame, layerReq, layerRGB, backGroundRGB,
           prioWr, prioRank, prioLayer, layerEnNext,
    output redOut, greenOut, blueOut, collFrame, collAny
  );

endinterface

// File: rtl/objects_mux_layered_rgb_priority_select.sv
// Combinational first-set finder over rank-ordered requests: the lowest
// rank slot with its request set supplies the colour, else the background.
module rgb_priority_select
  import objects_mux_pkg::*;
#(
  parameter int NUM_LAYERS = 8
) (
  input  logic [NUM_LAYERS-1:0]    i_eff,
  input  rgb332_t [NUM_LAYERS-1:0] i_rgb,
  input  rgb332_t                  i_bg,
  output rgb332_t                  o_rgb
);

  // Scan from the lowest priority upwards so the highest-priority hit is the last write.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned and no latch is inferred.
    o_rgb = i_bg;
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (i_eff[s]) o_rgb = i_rgb[s];
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// Parametrised N-layer pixel compositor for the VGA path.
// Per pixel, the highest-ranked requesting layer wins (else background) and
// the RGB332 result is expanded to 24-bit. Rank table and layer enables are
// programmed into shadow copies and take effect at startOfFrame. Latency is
// 2 clk, one pixel per clock.
// Optional build macro: OBJMUX_COLLISION_EN enables per-frame collision
// reporting on collFrame/collAny; without it both are tied to 0.
module objects_mux_layered
  import objects_mux_pkg::*;
#(
  parameter int      NUM_LAYERS = 8,
  parameter int      RANK_W     = $clog2(NUM_LAYERS),
  parameter rgb332_t TRANSP_KEY = TRANSP_KEY_DEF
) (
  input logic                   clk,
  input logic                   resetN,
  objects_mux_layered_if.slave  bus
);

  logic [RANK_W-1:0]         r_shadow [NUM_LAYERS];
  logic [RANK_W-1:0]         r_active [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]     r_active_en;

  rgb332_t                   w_layer_rgb [NUM_LAYERS];
  logic [RANK_W-1:0]         w_tab [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]     w_en;
  logic [NUM_LAYERS-1:0]     w_eff;
  logic [NUM_LAYERS-1:0]     w_rank_eff;
  rgb332_t [NUM_LAYERS-1:0]  w_rank_rgb;
  logic                      w_wr_ok;

  logic [NUM_LAYERS-1:0]     r_s1_eff;
  rgb332_t [NUM_LAYERS-1:0]  r_s1_rgb;
  rgb332_t                   r_s1_bg;

  rgb332_t                   w_sel;
  rgb888_t                   r_out;

  // Out-of-range slot or layer indices are dropped rather than aliased.
  assign w_wr_ok = bus.prioWr
                && (int'(bus.prioRank)  < NUM_LAYERS)
                && (int'(bus.prioLayer) < NUM_LAYERS);

  // Shadow rank table: software writes land here at any time.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: the tables are small flop arrays, not RAM, so each entry can and does take a reset value.
    if (!resetN) begin
      for (int r = 0; r < NUM_LAYERS; r++) r_shadow[r] <= RANK_W'(r);
    end else if (w_wr_ok) begin
      r_shadow[bus.prioRank] <= bus.prioLayer;
    end
  end

  // Active rank table and enables: copied from the shadow state only at frame start.
  always_ff @(posedge clk or negedge resetN) begin
    // NOTE: non-blocking assignments here mean a same-cycle shadow write is not seen; active gets the pre-write table.
    if (!resetN) begin
      for (int r = 0; r < NUM_LAYERS; r++) r_active[r] <= RANK_W'(r);
      r_active_en <= '1;
    end else if (bus.startOfFrame) begin
      for (int r = 0; r < NUM_LAYERS; r++) r_active[r] <= r_shadow[r];
      r_active_en <= bus.layerEnNext;
    end
  end

  // The startOfFrame pixel is the first pixel of the new frame, so it already uses the incoming table and enables.
  always_comb begin
    for (int r = 0; r < NUM_LAYERS; r++) begin
      w_tab[r]       = bus.startOfFrame ? r_shadow[r] : r_active[r];
      w_layer_rgb[r] = bus.layerRGB[8*r +: 8];
    end
    w_en = bus.startOfFrame ? bus.layerEnNext : r_active_en;
  end

  // Effective per-layer request, then reorder layers into rank order.
  always_comb begin
    w_eff      = '0;
    w_rank_eff = '0;
    w_rank_rgb = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_eff[i] = bus.layerReq[i] & w_en[i] & (w_layer_rgb[i] != TRANSP_KEY);
    end
    for (int s = 0; s < NUM_LAYERS; s++) begin
      w_rank_eff[s] = w_eff[w_tab[s]];
      w_rank_rgb[s] = w_layer_rgb[w_tab[s]];
    end
  end

  // Stage 1: register rank-ordered requests/colours and the matching background.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_eff <= '0;
      r_s1_rgb <= '0;
      r_s1_bg  <= '0;
    end else begin
      r_s1_eff <= w_rank_eff;
      r_s1_rgb <= w_rank_rgb;
      r_s1_bg  <= bus.backGroundRGB;
    end
  end

  rgb_priority_select #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_select (
    .i_eff (r_s1_eff),
    .i_rgb (r_s1_rgb),
    .i_bg  (r_s1_bg),
    .o_rgb (w_sel)
  );

  // Stage 2: register the winning colour expanded to 24-bit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_out <= '0;
    else         r_out <= expand332(w_sel);
  end

  assign bus.redOut   = r_out.r;
  assign bus.greenOut = r_out.g;
  assign bus.blueOut  = r_out.b;

`ifdef OBJMUX_COLLISION_EN
  logic [NUM_LAYERS-1:0] w_hits;
  logic [NUM_LAYERS-1:0] r_coll_acc;
  logic [NUM_LAYERS-1:0] r_coll_frame;
  logic                  r_coll_any;

  // A layer collides on a pixel when it is effective together with at least one other layer.
  assign w_hits = multi_hot(NUM_LAYERS_MAX'(w_eff)) ? w_eff : '0;

  // Accumulate hits over a frame; publish and restart at frame start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_coll_acc   <= '0;
      r_coll_frame <= '0;
      r_coll_any   <= 1'b0;
    end else if (bus.startOfFrame) begin
      r_coll_frame <= r_coll_acc;
      r_coll_any   <= |r_coll_acc;
      r_coll_acc   <= w_hits;
    end else begin
      r_coll_acc   <= r_coll_acc | w_hits;
    end
  end

  assign bus.collFrame = r_coll_frame;
  assign bus.collAny   = r_coll_any;
`else
  assign bus.collFrame = '0;
  assign bus.collAny   = 1'b0;
`endif

endmodule
